// File: rtl/counter_updn_mod.sv
// Up/down counter with configurable limits.
// Behaviour at the limits is set by SATURATE: the count either wraps with a
// one-cycle pulse on o_wrap, or holds and sets the sticky flag o_sat.
// Each clock edge applies i_sclr first, then i_load, then i_en.
// o_tc is combinational so that counters can be cascaded.
module counter_updn_mod #(
    parameter int unsigned        WIDTH    = 4,
    parameter logic [WIDTH-1:0]   LLIMIT   = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]   ULIMIT   = {WIDTH{1'b1}},
    parameter bit                 SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sclr,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_ld_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_sat
);

    // Stop elaboration when the parameters describe an impossible counter.
    if ((WIDTH < 32'd2) || (WIDTH > 32'd32)) begin : g_bad_width
        $error("counter_updn_mod: WIDTH must be in the range 2..32");
    end
    if (!(LLIMIT < ULIMIT)) begin : g_bad_limits
        $error("counter_updn_mod: LLIMIT must be strictly below ULIMIT");
    end

    localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

    // Force a load value into [LLIMIT, ULIMIT].
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] res;
        if (val < LLIMIT) begin
            res = LLIMIT;
        end else if (val > ULIMIT) begin
            res = ULIMIT;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic [WIDTH-1:0] cnt_r;
    logic             wrap_r;
    logic             sat_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             wrap_nxt_s;
    logic             sat_nxt_s;
    logic             at_top_s;
    logic             at_bot_s;

    assign at_top_s = (cnt_r == ULIMIT);
    assign at_bot_s = (cnt_r == LLIMIT);

    // Next-state selection. Increment and decrement happen only strictly
    // inside the range, so the WIDTH-bit arithmetic never overflows, even
    // when ULIMIT is all-ones.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        wrap_nxt_s = 1'b0;
        sat_nxt_s  = sat_r;
        if (i_sclr) begin
            cnt_nxt_s = LLIMIT;
            sat_nxt_s = 1'b0;
        end else if (i_load) begin
            cnt_nxt_s = clamp_load(i_ld_val);
            sat_nxt_s = 1'b0;
        end else if (i_en) begin
            if (i_up) begin
                if (at_top_s) begin
                    if (SATURATE) begin
                        sat_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s  = LLIMIT;
                        wrap_nxt_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + ONE_C;
                end
            end else begin
                if (at_bot_s) begin
                    if (SATURATE) begin
                        sat_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s  = ULIMIT;
                        wrap_nxt_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - ONE_C;
                end
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers. Reset is asynchronous so that it also cancels a
    // wrap pulse that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= LLIMIT;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            wrap_r <= wrap_nxt_s;
            sat_r  <= sat_nxt_s;
        end
    end

    assign o_cnt  = cnt_r;
    assign o_wrap = wrap_r;
    assign o_sat  = sat_r;
    assign o_tc   = i_en & ~i_sclr & ~i_load & ((i_up & at_top_s) | (~i_up & at_bot_s));

endmodule

// File: tb/tb_counter_updn_mod.sv
// Bench for counter_updn_mod. Three instances share the same stimulus:
//   0: limits 2..11, wrapping   1: limits 2..11, saturating   2: defaults (0..15)
// A range-arithmetic model predicts every output and is compared on each
// falling edge; directed literal checks pin the model to known values.
`timescale 1ns/100ps
module tb_counter_updn_mod;

    logic       clk;
    logic       rst;
    logic       sclr;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] ld_val;
    logic [3:0] cnt_o [3];
    logic       tc_o  [3];
    logic       wrap_o[3];
    logic       sat_o [3];

    int checks = 0;
    int errors = 0;

    int lo_c  [3] = '{2, 2, 0};
    int hi_c  [3] = '{11, 11, 15};
    int smode [3] = '{0, 1, 0};

    int m_cnt [3];
    int m_wrap[3];
    int m_sat [3];

    counter_updn_mod #(.WIDTH(4), .LLIMIT(4'd2), .ULIMIT(4'd11), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .i_sclr(sclr), .i_en(en), .i_up(up), .i_load(load),
        .i_ld_val(ld_val), .o_cnt(cnt_o[0]), .o_tc(tc_o[0]), .o_wrap(wrap_o[0]), .o_sat(sat_o[0]));

    counter_updn_mod #(.WIDTH(4), .LLIMIT(4'd2), .ULIMIT(4'd11), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .i_sclr(sclr), .i_en(en), .i_up(up), .i_load(load),
        .i_ld_val(ld_val), .o_cnt(cnt_o[1]), .o_tc(tc_o[1]), .o_wrap(wrap_o[1]), .o_sat(sat_o[1]));

    counter_updn_mod dut_d (
        .clk(clk), .rst(rst), .i_sclr(sclr), .i_en(en), .i_up(up), .i_load(load),
        .i_ld_val(ld_val), .o_cnt(cnt_o[2]), .o_tc(tc_o[2]), .o_wrap(wrap_o[2]), .o_sat(sat_o[2]));

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the count is a position inside [lo, hi]; a step that
    // leaves the range either wraps modulo the range size or is refused.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            int raw;
            int n;
            n   = hi_c[k] - lo_c[k] + 1;
            raw = m_cnt[k] + (up ? 1 : -1);
            if (rst) begin
                m_cnt[k] <= lo_c[k]; m_wrap[k] <= 0; m_sat[k] <= 0;
            end else if (sclr) begin
                m_cnt[k] <= lo_c[k]; m_wrap[k] <= 0; m_sat[k] <= 0;
            end else if (load) begin
                m_cnt[k]  <= (int'(ld_val) < lo_c[k]) ? lo_c[k] :
                             (int'(ld_val) > hi_c[k]) ? hi_c[k] : int'(ld_val);
                m_wrap[k] <= 0; m_sat[k] <= 0;
            end else if (en && (raw < lo_c[k] || raw > hi_c[k])) begin
                if (smode[k] != 0) begin
                    m_sat[k] <= 1; m_wrap[k] <= 0;
                end else begin
                    m_cnt[k]  <= lo_c[k] + ((((raw - lo_c[k]) % n) + n) % n);
                    m_wrap[k] <= 1;
                end
            end else if (en) begin
                m_cnt[k] <= raw; m_wrap[k] <= 0;
            end else begin
                m_wrap[k] <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int tc_exp;
            tc_exp = (en && !sclr && !load &&
                      ((up && m_cnt[k] == hi_c[k]) || (!up && m_cnt[k] == lo_c[k]))) ? 1 : 0;
            check($sformatf("model_cnt[%0d]", k),  {28'd0, cnt_o[k]}, m_cnt[k]);
            check($sformatf("model_wrap[%0d]", k), {31'd0, wrap_o[k]}, m_wrap[k]);
            check($sformatf("model_sat[%0d]", k),  {31'd0, sat_o[k]}, m_sat[k]);
            check($sformatf("model_tc[%0d]", k),   {31'd0, tc_o[k]}, tc_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [3:0] v);
        load   = 1'b1;
        ld_val = v;
        step();
        load   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sclr = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; ld_val = 4'd0;
        // Async reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_cnt_w", {28'd0, cnt_o[0]}, 2);
        check("rst_wrap_w", {31'd0, wrap_o[0]}, 0);
        check("rst_sat_s", {31'd0, sat_o[1]}, 0);
        check("rst_cnt_d", {28'd0, cnt_o[2]}, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Wrap up.
        do_load(4'd2);
        en = 1'b1; up = 1'b1;
        repeat (9) step();
        check("up_cnt_11", {28'd0, cnt_o[0]}, 11);
        check("up_tc", {31'd0, tc_o[0]}, 1);
        step();
        check("up_wrap_cnt", {28'd0, cnt_o[0]}, 2);
        check("up_wrap_pulse", {31'd0, wrap_o[0]}, 1);
        check("up_sat_held", {28'd0, cnt_o[1]}, 11);
        check("up_sat_flag", {31'd0, sat_o[1]}, 1);
        check("up_d_cnt", {28'd0, cnt_o[2]}, 12);
        step();
        check("up_after_cnt", {28'd0, cnt_o[0]}, 3);
        check("up_after_wrap", {31'd0, wrap_o[0]}, 0);
        en = 1'b0;

        // Wrap down.
        do_load(4'd2);
        en = 1'b1; up = 1'b0;
        #1;
        check("dn_tc", {31'd0, tc_o[0]}, 1);
        step();
        check("dn_wrap_cnt", {28'd0, cnt_o[0]}, 11);
        check("dn_wrap_pulse", {31'd0, wrap_o[0]}, 1);
        step();
        check("dn_after_cnt", {28'd0, cnt_o[0]}, 10);
        check("dn_after_wrap", {31'd0, wrap_o[0]}, 0);
        en = 1'b0;

        // Saturate.
        do_load(4'd11);
        check("sat_cleared_by_load", {31'd0, sat_o[1]}, 0);
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat_cnt", {28'd0, cnt_o[1]}, 11);
            check("sat_flag", {31'd0, sat_o[1]}, 1);
            check("sat_no_wrap", {31'd0, wrap_o[1]}, 0);
        end
        en = 1'b0;
        do_load(4'd5);
        check("sat_reload_cnt", {28'd0, cnt_o[1]}, 5);
        check("sat_reload_flag", {31'd0, sat_o[1]}, 0);

        // Clamp and priority.
        do_load(4'd14);
        check("clamp_hi_w", {28'd0, cnt_o[0]}, 11);
        check("clamp_hi_d", {28'd0, cnt_o[2]}, 14);
        do_load(4'd0);
        check("clamp_lo_w", {28'd0, cnt_o[0]}, 2);
        do_load(4'd7);
        sclr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; ld_val = 4'd9;
        step();
        check("prio_sclr_w", {28'd0, cnt_o[0]}, 2);
        check("prio_sclr_d", {28'd0, cnt_o[2]}, 0);
        sclr = 1'b0; load = 1'b0; en = 1'b0;

        // Async reset mid-count, then resume.
        do_load(4'd7);
        en = 1'b1; up = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("arst_cnt", {28'd0, cnt_o[0]}, 2);
        check("arst_wrap", {31'd0, wrap_o[0]}, 0);
        check("arst_sat", {31'd0, sat_o[1]}, 0);
        rst = 1'b0;
        step();
        check("arst_resume", {28'd0, cnt_o[0]}, 3);

        // Async reset during a wrap pulse.
        do_load(4'd11);
        step();
        check("pulse_before_rst", {31'd0, wrap_o[0]}, 1);
        #1 rst = 1'b1;
        #1;
        check("pulse_aborted", {31'd0, wrap_o[0]}, 0);
        rst = 1'b0;
        en = 1'b0;

        // Full-range defaults.
        do_load(4'd15);
        check("full_at_15", {28'd0, cnt_o[2]}, 15);
        en = 1'b1; up = 1'b1;
        step();
        check("full_wrap_cnt", {28'd0, cnt_o[2]}, 0);
        check("full_wrap_pulse", {31'd0, wrap_o[2]}, 1);
        check("full_no_x", {31'd0, $isunknown(cnt_o[2])}, 0);
        en = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
